// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - datapath and memory-arbiter signal bundle for dcache_ctrl
interface dcache_ctrl_if;
    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    modport slave (
        input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport master (
        output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl #(
    parameter logic [31:0] HIT_CNT_ADDR = 32'h0000_3100,
    parameter int          NSETS        = 8
) (
    input  logic         CLK,
    input  logic         nRST,
    dcache_ctrl_if.slave bus
);
    typedef struct packed {
        logic [25:0] tag;
        logic        valid;
        logic        dirty;
        logic [31:0] data1;
        logic [31:0] data2;
    } Dcache_t;

    typedef enum logic [3:0] {
        IDLE_D, WB1, WB2, LD1, LD2, FLUSH1, FLUSH2, HLT_CNT, HALT, IDLE_CNT, CLEAN
    } Dstate_t;

    Dstate_t     state, next_state;
    Dcache_t     frames [NSETS];
    logic [31:0] hit_cnt;
    logic [31:0] load_q;
    logic        miss_flag;
    logic [2:0]  flush_idx;

    logic [25:0] req_tag;
    logic [2:0]  req_idx;
    logic        req_word;
    logic        req;
    logic        hit;
    logic        fl_dirty;
    logic [31:0] hit_word;
    logic [1:0]  unused_addr_bits;
    Dcache_t     cur;
    Dcache_t     fl;

    assign req_tag          = bus.dmemaddr[31:6];
    assign req_idx          = bus.dmemaddr[5:3];
    assign req_word         = bus.dmemaddr[2];
    assign unused_addr_bits = bus.dmemaddr[1:0];
    assign req              = bus.dmemREN | bus.dmemWEN;
    assign cur              = frames[req_idx];
    assign fl               = frames[flush_idx];
    assign fl_dirty         = fl.valid & fl.dirty;
    assign hit_word         = req_word ? cur.data2 : cur.data1;
    // halt in IDLE_D pre-empts the request, so it is neither a hit nor a miss
    assign hit = (state == IDLE_D) && !bus.halt && req && cur.valid && (cur.tag == req_tag);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE_D;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE_D: begin
                if (bus.halt)          next_state = FLUSH1;
                else if (req && !hit)  next_state = (cur.valid && cur.dirty) ? WB1 : LD1;
            end
            WB1:     if (!bus.dwait) next_state = WB2;
            WB2:     if (!bus.dwait) next_state = LD1;
            LD1:     if (!bus.dwait) next_state = LD2;
            LD2:     if (!bus.dwait) next_state = IDLE_D;
            FLUSH1: begin
                if (fl_dirty) begin
                    if (!bus.dwait) next_state = FLUSH2;
                end else if (flush_idx == 3'd7) begin
                    next_state = HLT_CNT;
                end
            end
            FLUSH2:  if (!bus.dwait) next_state = (flush_idx == 3'd7) ? HLT_CNT : FLUSH1;
            HLT_CNT: if (!bus.dwait) next_state = HALT;
            HALT:    next_state = HALT;
            default: next_state = IDLE_D;
        endcase
    end

    always_comb begin
        bus.dhit     = 1'b0;
        bus.dmemload = load_q;
        bus.flushed  = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'd0;
        bus.dstore   = 32'd0;
        case (state)
            IDLE_D: begin
                bus.dhit = hit;
                if (hit && !bus.dmemWEN) bus.dmemload = hit_word;
            end
            WB1: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {cur.tag, req_idx, 3'b000};
                bus.dstore = cur.data1;
            end
            WB2: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {cur.tag, req_idx, 3'b100};
                bus.dstore = cur.data2;
            end
            LD1: begin
                bus.dREN  = 1'b1;
                bus.daddr = {req_tag, req_idx, 3'b000};
            end
            LD2: begin
                bus.dREN  = 1'b1;
                bus.daddr = {req_tag, req_idx, 3'b100};
            end
            FLUSH1: begin
                if (fl_dirty) begin
                    bus.dWEN   = 1'b1;
                    bus.daddr  = {fl.tag, flush_idx, 3'b000};
                    bus.dstore = fl.data1;
                end
            end
            FLUSH2: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {fl.tag, flush_idx, 3'b100};
                bus.dstore = fl.data2;
            end
            HLT_CNT: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = HIT_CNT_ADDR;
                bus.dstore = hit_cnt;
            end
            HALT:    bus.flushed = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NSETS; i++) frames[i] <= '0;
            hit_cnt   <= 32'd0;
            load_q    <= 32'd0;
            miss_flag <= 1'b0;
            flush_idx <= 3'd0;
        end else begin
            case (state)
                IDLE_D: begin
                    if (hit) begin
                        if (bus.dmemWEN) begin
                            if (req_word) frames[req_idx].data2 <= bus.dmemstore;
                            else          frames[req_idx].data1 <= bus.dmemstore;
                            frames[req_idx].dirty <= 1'b1;
                        end else begin
                            load_q <= hit_word;
                        end
                        // the hit that follows a refill replays the miss and is not counted
                        if (!miss_flag) hit_cnt <= hit_cnt + 32'd1;
                        miss_flag <= 1'b0;
                    end else if (req && !bus.halt) begin
                        miss_flag <= 1'b1;
                    end
                end
                LD1: if (!bus.dwait) frames[req_idx].data1 <= bus.dload;
                LD2: begin
                    if (!bus.dwait) begin
                        frames[req_idx].data2 <= bus.dload;
                        frames[req_idx].tag   <= req_tag;
                        frames[req_idx].valid <= 1'b1;
                        frames[req_idx].dirty <= 1'b0;
                    end
                end
                FLUSH1: if (!fl_dirty) flush_idx <= flush_idx + 3'd1;
                FLUSH2: begin
                    if (!bus.dwait) begin
                        frames[flush_idx].dirty <= 1'b0;
                        flush_idx               <= flush_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
    logic CLK;
    logic nRST;
    int   n_checks = 0;
    int   n_pass   = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        log_q [$];
    logic [31:0] mem [logic [31:0]];

    dcache_ctrl_if bus ();

    dcache_ctrl #(.HIT_CNT_ADDR(32'h0000_3100), .NSETS(8)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic expect_txn(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        if (log_q.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
            return;
        end
        t = log_q.pop_front();
        check({tag, "_kind"}, 32'(t.wr), 32'(wr));
        check({tag, "_addr"}, t.addr, a);
        check({tag, "_data"}, t.data, d);
    endtask

    task automatic do_req(input logic wen, input logic ren, input logic [31:0] addr,
                          input logic [31:0] data, output int waited, output logic [31:0] load);
        @(negedge CLK);
        bus.dmemWEN   = wen;
        bus.dmemREN   = ren;
        bus.dmemaddr  = addr;
        bus.dmemstore = data;
        waited = 0;
        #1;
        while (!bus.dhit && waited < 200) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        check("req_served", 32'(bus.dhit), 32'd1);
        load = bus.dmemload;
        @(posedge CLK);
        #1;
        bus.dmemWEN = 1'b0;
        bus.dmemREN = 1'b0;
    endtask

    // memory arbiter: two busy cycles, then completes the transfer
    initial begin
        int wcnt;
        wcnt      = 0;
        bus.dwait = 1'b1;
        bus.dload = 32'd0;
        forever begin
            @(negedge CLK);
            if (!nRST || !(bus.dREN || bus.dWEN)) begin
                wcnt      = 0;
                bus.dwait = 1'b1;
            end else if (wcnt < 2) begin
                wcnt++;
                bus.dwait = 1'b1;
            end else begin
                wcnt      = 0;
                bus.dwait = 1'b0;
                if (bus.dWEN) begin
                    mem[bus.daddr] = bus.dstore;
                    log_q.push_back({1'b1, bus.daddr, bus.dstore});
                end else begin
                    bus.dload = mem.exists(bus.daddr) ? mem[bus.daddr] : 32'd0;
                    log_q.push_back({1'b0, bus.daddr, bus.dload});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          waited;
        logic [31:0] load;

        nRST          = 1'b0;
        bus.halt      = 1'b0;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = 32'd0;
        bus.dmemstore = 32'd0;
        mem[32'h40]  = 32'hAAAA_0001;
        mem[32'h44]  = 32'hAAAA_0002;
        mem[32'h840] = 32'hBBBB_0001;
        mem[32'h844] = 32'hBBBB_0002;
        mem[32'h6C]  = 32'h6666_0006;

        repeat (2) @(negedge CLK);
        #1;
        check("rst_dhit",     32'(bus.dhit),    32'd0);
        check("rst_flushed",  32'(bus.flushed), 32'd0);
        check("rst_dren",     32'(bus.dREN),    32'd0);
        check("rst_dwen",     32'(bus.dWEN),    32'd0);
        check("rst_daddr",    bus.daddr,        32'd0);
        check("rst_dstore",   bus.dstore,       32'd0);
        check("rst_dmemload", bus.dmemload,     32'd0);
        nRST = 1'b1;

        // cold read miss
        do_req(1'b0, 1'b1, 32'h44, 32'd0, waited, load);
        check("cold_load", load, 32'hAAAA_0002);
        check("cold_missed", 32'(waited > 0), 32'd1);
        expect_txn("cold_w0", 1'b0, 32'h40, 32'hAAAA_0001);
        expect_txn("cold_w1", 1'b0, 32'h44, 32'hAAAA_0002);
        check("cold_log_done", 32'(log_q.size()), 32'd0);

        // write hit then re-read
        do_req(1'b1, 1'b0, 32'h40, 32'h1234_5678, waited, load);
        check("wr_hit_same_cycle", 32'(waited), 32'd0);
        do_req(1'b0, 1'b1, 32'h40, 32'd0, waited, load);
        check("rd_hit_same_cycle", 32'(waited), 32'd0);
        check("rd_hit_load", load, 32'h1234_5678);
        check("hit_no_traffic", 32'(log_q.size()), 32'd0);

        // dirty eviction
        do_req(1'b0, 1'b1, 32'h840, 32'd0, waited, load);
        check("evict_load", load, 32'hBBBB_0001);
        expect_txn("evict_wb0", 1'b1, 32'h40,  32'h1234_5678);
        expect_txn("evict_wb1", 1'b1, 32'h44,  32'hAAAA_0002);
        expect_txn("evict_ld0", 1'b0, 32'h840, 32'hBBBB_0001);
        expect_txn("evict_ld1", 1'b0, 32'h844, 32'hBBBB_0002);
        check("evict_log_done", 32'(log_q.size()), 32'd0);

        // dirty frames 0 and 5
        do_req(1'b1, 1'b0, 32'h840, 32'hC0C0_0000, waited, load);
        check("f0_wr_hit", 32'(waited), 32'd0);
        do_req(1'b1, 1'b1, 32'h68, 32'h5555_5555, waited, load);
        expect_txn("f5_ld0", 1'b0, 32'h68, 32'h0000_0000);
        expect_txn("f5_ld1", 1'b0, 32'h6C, 32'h6666_0006);
        check("f5_log_done", 32'(log_q.size()), 32'd0);

        // halt together with a read miss
        @(negedge CLK);
        bus.halt     = 1'b1;
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h1000;
        #1;
        check("halt_req_dhit", 32'(bus.dhit), 32'd0);
        check("halt_req_dren", 32'(bus.dREN), 32'd0);
        waited = 0;
        while (!bus.flushed && waited < 500) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        check("flushed_set", 32'(bus.flushed), 32'd1);
        expect_txn("fl_f0_w0", 1'b1, 32'h840,  32'hC0C0_0000);
        expect_txn("fl_f0_w1", 1'b1, 32'h844,  32'hBBBB_0002);
        expect_txn("fl_f5_w0", 1'b1, 32'h68,   32'h5555_5555);
        expect_txn("fl_f5_w1", 1'b1, 32'h6C,   32'h6666_0006);
        expect_txn("fl_hitcnt", 1'b1, 32'h3100, 32'd3);
        check("flush_log_done", 32'(log_q.size()), 32'd0);
        repeat (3) @(negedge CLK);
        #1;
        check("flushed_held", 32'(bus.flushed), 32'd1);
        check("halt_quiet", 32'(bus.dWEN | bus.dREN), 32'd0);

        // reset mid write-back
        bus.halt    = 1'b0;
        bus.dmemREN = 1'b0;
        nRST        = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        nRST = 1'b1;
        log_q.delete();
        do_req(1'b0, 1'b1, 32'h40, 32'd0, waited, load);
        check("post_halt_refill", load, 32'h1234_5678);
        do_req(1'b1, 1'b0, 32'h40, 32'h0BAD_F00D, waited, load);
        log_q.delete();
        @(negedge CLK);
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h840;
        waited = 0;
        #1;
        while (!(bus.dWEN && bus.daddr == 32'h44) && waited < 200) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        check("reached_wb2", 32'(bus.dWEN && bus.daddr == 32'h44), 32'd1);
        nRST = 1'b0;
        #1;
        check("rst_mid_dwen", 32'(bus.dWEN), 32'd0);
        check("rst_mid_dren", 32'(bus.dREN), 32'd0);
        bus.dmemREN = 1'b0;
        expect_txn("rst_mid_wb0", 1'b1, 32'h40, 32'h0BAD_F00D);
        check("rst_mid_log_done", 32'(log_q.size()), 32'd0);
        repeat (2) @(negedge CLK);
        #1;
        nRST = 1'b1;
        do_req(1'b0, 1'b1, 32'h40, 32'd0, waited, load);
        check("post_rst_missed", 32'(waited > 0), 32'd1);
        check("post_rst_load", load, 32'h0BAD_F00D);
        expect_txn("post_rst_ld0", 1'b0, 32'h40, 32'h0BAD_F00D);
        expect_txn("post_rst_ld1", 1'b0, 32'h44, 32'hAAAA_0002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache between the pipeline memory stage and the memory arbiter.
- Holds 8 frames of the Dcache_t record from diaosi_types_pkg: 26-bit tag, valid, dirty, two 32-bit words.
- Sequenced by a Dstate_t state register.
- On halt, writes back all dirty frames, stores the hit count, then asserts flushed.

Parameters:
HIT_CNT_ADDR, 32'h0000_3100, word address where the hit count is stored during halt.
NSETS, 8, number of frames; fixed by the address split below, not meant to be overridden.

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
halt  in  1  pipeline halt request, level
dmemREN  in  1  datapath load request
dmemWEN  in  1  datapath store request
dmemaddr  in  32  datapath byte address
dmemstore  in  32  store data
dhit  out  1  request served this cycle
dmemload  out  32  load data, valid when dhit=1
flushed  out  1  flush and hit-count store complete
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory word address
dstore  out  32  memory write data
dwait  in  1  memory busy; a transfer completes in the cycle dwait=0 with a request asserted
dload  in  32  memory read data

Behaviour:
- Reset:
  - All frames are cleared: valid=0, dirty=0, tag=0, data=0.
  - Hit counter = 0, miss flag = 0, flush index = 0, state = IDLE_D.
  - All outputs are 0.
  - Reset is asynchronous and overrides any state, including an in-flight memory transfer.
- Address split: tag=addr[31:6], index=addr[5:3], word select=addr[2], addr[1:0] ignored. Memory word 0 of a block is at {tag,index,3'b000}; word 1 is at {tag,index,3'b100}.
- Request priority: if both dmemWEN and dmemREN are set, the request is treated as a write. If halt is set in IDLE_D, it takes priority over any request; the request is not served.
- IDLE_D:
  - Hit (valid and tag match) with a request, combinational same cycle:
    - dhit=1.
    - Read: dmemload = the selected word.
    - Write: the selected word is updated and dirty=1 on the clock edge.
    - Hit counter +1 unless the miss flag is set; the miss flag is cleared.
  - Miss with a request: dhit=0, miss flag set. If the frame is valid and dirty, go to WB1; otherwise go to LD1.
  - No request and no halt: stay in IDLE_D, all memory outputs 0.
- Write-back of the victim frame:
  - WB1: dWEN=1, daddr = victim word 0 address, dstore=data1. Go to WB2 when dwait=0.
  - WB2: the same for word 1 (data2). Go to LD1 when dwait=0.
- Refill:
  - LD1: dREN=1, daddr = requested word 0 address. When dwait=0, latch dload into data1 and go to LD2.
  - LD2: dREN=1, daddr = word 1 address. When dwait=0, latch data2; set tag, valid=1, dirty=0; go to IDLE_D.
  - The request is then re-evaluated as a hit, which does not count because the miss flag is set.
- dhit is never asserted outside IDLE_D. dmemload holds its last value when dhit=0.
- Flush, entered when halt=1 in IDLE_D:
  - FLUSH1: if frame[flush index] is valid and dirty, dWEN=1, daddr = word 0 address of that frame, dstore=data1; go to FLUSH2 when dwait=0. Otherwise no request this cycle and the index advances.
  - FLUSH2: write word 1 of the same frame. When dwait=0, clear dirty, advance the index, return to FLUSH1.
  - When the index reaches 7 and frame 7 is done or skipped, go to HLT_CNT.
- HLT_CNT: dWEN=1, daddr=HIT_CNT_ADDR, dstore = hit counter. Go to HALT when dwait=0.
- HALT: flushed=1 and no memory requests. This state is terminal until reset.
- IDLE_CNT and CLEAN are not reachable; the default branch returns to IDLE_D.
- Request and address outputs change only with state; data captures happen only on edges where dwait=0.
- Hit counter is 32 bits and wraps modulo 2^32.

Test Plan:
- Cold read miss: reset, then dmemREN at 0x0000_0044 with memory returning 0xAAAA_0001/0xAAAA_0002 at 0x40/0x44 (dwait=1 for 2 cycles per word) -> two dREN transfers at 0x40 and 0x44, then dhit=1 with dmemload=0xAAAA_0002. Hit count stays 0.
- Write hit then re-read: after the fill above, dmemWEN at 0x40 with data 0x1234_5678 -> dhit in the same cycle, no memory traffic. A read of 0x40 returns 0x1234_5678 and the hit count is 2.
- Dirty eviction: dirty frame 0 with tag for 0x40, then a read of 0x0000_0840 (same index, new tag) -> dWEN at 0x40 then 0x44 with the old data, then dREN at 0x840 and 0x844, then dhit.
- Halt flush: frames 0 and 5 dirty, halt=1 -> dWEN for the frame 0 words, then the frame 5 words only. Next, dWEN at 0x3100 with the hit count, then flushed=1 held.
- Reset mid-transfer: assert nRST=0 during WB2 with dwait=1 -> dWEN/dREN drop to 0 immediately. After release, a read of the prior address misses.
- Simultaneous halt and read miss in IDLE_D -> no dREN is issued; flush begins instead.
